// File: rtl/booth_div_if.sv
// booth_div_if: divider handshake bundle (start/dvd/dvs in; quot/rem/busy/done/ovf/dz out); master drives operands, slave is the divider
interface booth_div_if #(parameter int N = 4);
  logic             start;
  logic [2*N-1:0]   dvd;
  logic [N-1:0]     dvs;
  logic [N-1:0]     quot;
  logic [N-1:0]     rem;
  logic             busy;
  logic             done;
  logic             ovf;
  logic             dz;
  modport master(output start, dvd, dvs, input quot, rem, busy, done, ovf, dz);
  modport slave(input start, dvd, dvs, output quot, rem, busy, done, ovf, dz);
endinterface

// File: rtl/booth_div.sv
// booth_div: signed 2N/N restoring divider (clk, async active-high rst, bus: start/dvd/dvs in, quot/rem/busy/done/ovf/dz out)
module booth_div #(parameter int N = 4) (
  input logic         clk,
  input logic         rst,
  booth_div_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [N:0]     pr;
  logic [N-1:0]   lo, mdvs, mdvs_in, qs, rs;
  logic [2*N-1:0] mdvd;
  logic [N:0]     sh;
  logic           ge, sign_q, sign_r, zero, big, range_bad, ok;
  always_comb begin
    mdvd      = bus.dvd[2*N-1] ? -bus.dvd : bus.dvd;
    mdvs_in   = bus.dvs[N-1] ? -bus.dvs : bus.dvs;
    sh        = {pr[N-1:0], lo[N-1]};
    ge        = sh >= {1'b0, mdvs};
    qs        = sign_q ? -lo : lo;
    rs        = sign_r ? -pr[N-1:0] : pr[N-1:0];
    // magnitude quotient may reach 2^(N-1) only when the result is negative
    range_bad = lo[N-1] && !(sign_q && lo[N-2:0] == '0);
    ok        = !zero && !big && !range_bad;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pr       <= '0;
      lo       <= '0;
      mdvs     <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero     <= 1'b0;
      big      <= 1'b0;
      bus.quot <= '0;
      bus.rem  <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.dz   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          sign_q   <= bus.dvd[2*N-1] ^ bus.dvs[N-1];
          sign_r   <= bus.dvd[2*N-1];
          mdvs     <= mdvs_in;
          pr       <= {1'b0, mdvd[2*N-1:N]};
          lo       <= mdvd[N-1:0];
          zero     <= bus.dvs == '0;
          // high half >= divisor means the quotient needs more than N bits
          big      <= mdvd[2*N-1:N] >= mdvs_in;
          cnt      <= '0;
          bus.busy <= 1'b1;
          state    <= CALC;
        end
        CALC: begin
          pr    <= ge ? sh - {1'b0, mdvs} : sh;
          lo    <= {lo[N-2:0], ge};
          cnt   <= cnt + 1'b1;
          state <= cnt == CW'(N-1) ? FIX : CALC;
        end
        FIX: begin
          bus.dz   <= zero;
          bus.ovf  <= !zero && (big || range_bad);
          bus.quot <= ok ? qs : '0;
          bus.rem  <= ok ? rs : '0;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_div.sv
// tb_booth_div: scoreboard bench for booth_div
module tb_booth_div;
  localparam int N = 4;
  typedef struct { logic [3:0] q, r; logic o, z; } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];
  booth_div_if #(.N(N)) bus ();
  booth_div #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic signed [7:0] a, input logic signed [3:0] b);
    exp_t e;
    int q, r;
    e = '{4'd0, 4'd0, 1'b0, 1'b0};
    if (b == 0) e.z = 1'b1;
    else begin
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
      if (q > 7 || q < -8) e.o = 1'b1;
      else begin
        e.q = q[3:0];
        e.r = r[3:0];
      end
    end
    return e;
  endfunction
  always @(negedge clk) if (!rst && bus.done) begin
    if (sb.size() == 0) check("extra_done", 1, 0);
    else begin
      exp_t e;
      e = sb.pop_front();
      check("quot", bus.quot, e.q);
      check("rem", bus.rem, e.r);
      check("ovf", bus.ovf, e.o);
      check("dz", bus.dz, e.z);
    end
  end
  task automatic issue(input logic signed [7:0] a, input logic signed [3:0] b);
    bus.dvd = a;
    bus.dvs = b;
    bus.start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input int first);
    int lat = first, bc = 0;
    while (!bus.done && lat < 30) begin
      if (bus.busy) bc++;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, N + 2);
    check("busy_cycles", bc, N + 2 - first);
  endtask
  task automatic do_div(input logic signed [7:0] a, input logic signed [3:0] b);
    @(negedge clk);
    check("done_pulse", bus.done, 0);
    issue(a, b);
    wait_done(1);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.dvd = '0;
    bus.dvs = '0;
    @(negedge clk);
    check("rst_quot", bus.quot, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_flags", {bus.ovf, bus.dz}, 0);
    rst = 1'b0;
    do_div(42, 6);
    do_div(-42, 6);
    do_div(43, -6);
    do_div(-43, -6);
    do_div(-64, 8);
    do_div(64, 4);
    do_div(64, -8);
    do_div(64, 8);
    do_div(-128, 1);
    do_div(8, 0);
    do_div(-128, -8);
    do_div(-1, 7);
    // start re-pulsed while busy must be ignored
    @(negedge clk);
    issue(42, 6);
    bus.dvd = -8'sd43;
    bus.dvs = -4'sd6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(2);
    // start on the done cycle is accepted
    issue(43, -6);
    wait_done(1);
    // reset mid-division aborts with no done
    do_div(43, -6);
    @(negedge clk);
    issue(42, 6);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_quot", bus.quot, 0);
    check("abort_rem", bus.rem, 0);
    check("abort_busy", bus.busy, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
    end
    for (int mc = -8; mc < 8; mc++)
      for (int mp = -8; mp < 8; mp++)
        if (mc != 0) begin
          int p;
          p = mc * mp;
          do_div(p[7:0], mc[3:0]);
        end
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
